key_sender: RTL



---
 rtl/key_sender.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/key_sender.sv
// key_sender: serial unlock-code transmitter for the lock FSM.
// Latches a parallel code on an accepted start strobe, holds the line idle-high
// for GUARD_CYC cycles, shifts the code out MSB first with each bit held
// bit_div+1 cycles, then waits up to TIMEOUT cycles for the lock's unlck
// feedback and reports the outcome with a one-cycle done or fail pulse.
//
// Optional feature macro: KEY_SENDER_RETRY_EN
//   defined     -> up to RETRIES re-sends of the latched code after a timeout
//   not defined -> first timeout ends the attempt with fail; no retry counter
//
// Ports:
//   clk      in   1         rising-edge clock
//   Reset    in   1         synchronous active-high reset
//   start    in   1         send request, honoured only when idle
//   code     in   CODE_LEN  code to send, bit CODE_LEN-1 first
//   bit_div  in   DIV_W     bit period minus one, in clk cycles
//   unlck    in   1         lock feedback, 1 = unlocked
//   a        out  1         serial line to the lock, idle high
//   busy     out  1         transfer in progress
//   done     out  1         one-cycle pulse, lock opened
//   fail     out  1         one-cycle pulse, all attempts timed out
module key_sender #(
  parameter int unsigned CODE_LEN  = 5,
  parameter int unsigned DIV_W     = 4,
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned RETRIES   = 2
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic [DIV_W-1:0]    bit_div,
  input  logic                unlck,
  output logic                a,
  output logic                busy,
  output logic                done,
  output logic                fail
);

  localparam int unsigned GUARD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned IDX_W   = (CODE_LEN > 1)  ? $clog2(CODE_LEN)  : 1;
  localparam int unsigned TO_W    = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;

  // Reject unusable parameterisations at elaboration.
  if (CODE_LEN < 1 || DIV_W < 1 || GUARD_CYC < 1 || TIMEOUT < 1 || RETRIES >= 65536) begin : g_bad_cfg
    $error("key_sender: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_SEND  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [CODE_LEN-1:0] r_code,      w_code_nxt;
  logic [DIV_W-1:0]    r_div,       w_div_nxt;
  logic [CODE_LEN-1:0] r_shift,     w_shift_nxt;
  logic [GUARD_W-1:0]  r_guard_cnt, w_guard_cnt_nxt;
  logic [DIV_W-1:0]    r_hold_cnt,  w_hold_cnt_nxt;
  logic [IDX_W-1:0]    r_idx,       w_idx_nxt;
  logic [TO_W-1:0]     r_to_cnt,    w_to_cnt_nxt;
  logic                r_a,         w_a_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic                r_fail,      w_fail_nxt;
  logic                w_timeout;

`ifdef KEY_SENDER_RETRY_EN
  localparam int unsigned RETRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  logic [RETRY_W-1:0]  r_retry_cnt, w_retry_cnt_nxt;
`endif

  assign a    = r_a;
  assign busy = r_busy;
  assign done = r_done;
  assign fail = r_fail;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_code      <= '0;
      r_div       <= '0;
      r_shift     <= '0;
      r_guard_cnt <= '0;
      r_hold_cnt  <= '0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_a         <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
`ifdef KEY_SENDER_RETRY_EN
      r_retry_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_div       <= w_div_nxt;
      r_shift     <= w_shift_nxt;
      r_guard_cnt <= w_guard_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_a         <= w_a_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_fail      <= w_fail_nxt;
`ifdef KEY_SENDER_RETRY_EN
      r_retry_cnt <= w_retry_cnt_nxt;
`endif
    end
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_div_nxt       = r_div;
    w_shift_nxt     = r_shift;
    w_guard_cnt_nxt = r_guard_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_idx_nxt       = r_idx;
    w_to_cnt_nxt    = r_to_cnt;
    w_done_nxt      = 1'b0;
    w_fail_nxt      = 1'b0;
`ifdef KEY_SENDER_RETRY_EN
    w_retry_cnt_nxt = r_retry_cnt;
`endif

    unique case (r_state)
      S_IDLE: begin
`ifdef KEY_SENDER_RETRY_EN
        w_retry_cnt_nxt = '0;
`endif
        // A start arriving while done/fail is still showing is dropped.
        if (start && !r_done && !r_fail) begin
          w_code_nxt      = code;
          w_div_nxt       = bit_div;
          w_guard_cnt_nxt = '0;
          w_state_nxt     = S_GUARD;
        end
      end

      S_GUARD: begin
        if (r_guard_cnt == GUARD_W'(GUARD_CYC - 1)) begin
          // Reload from the latched code so a retry re-sends the same bits.
          w_shift_nxt    = r_code;
          w_hold_cnt_nxt = '0;
          w_idx_nxt      = '0;
          w_state_nxt    = S_SEND;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt + GUARD_W'(1);
        end
      end

      S_SEND: begin
        if (r_hold_cnt == r_div) begin
          w_hold_cnt_nxt = '0;
          if (r_idx == IDX_W'(CODE_LEN - 1)) begin
            w_to_cnt_nxt = '0;
            w_state_nxt  = S_WAIT;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_shift_nxt = r_shift << 1;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + DIV_W'(1);
        end
      end

      S_WAIT: begin
        // unlck takes priority even on the final timeout cycle.
        if (unlck) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
`ifdef KEY_SENDER_RETRY_EN
          if (r_retry_cnt < RETRY_W'(RETRIES)) begin
            w_retry_cnt_nxt = r_retry_cnt + RETRY_W'(1);
            w_guard_cnt_nxt = '0;
            w_state_nxt     = S_GUARD;
          end else begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
`else
          w_fail_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line shows the current MSB only while sending; idle-high otherwise.
    w_a_nxt    = (w_state_nxt == S_SEND) ? w_shift_nxt[CODE_LEN-1] : 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

endmodule
